babbage_step_seq: RTL and testbench



---
 rtl/babbage_pkg.sv | 23 ++
 rtl/babbage_step_seq.sv | 169 ++++++++++++++++
 tb/tb_babbage_step_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/babbage_pkg.sv
// Shared types and phase codes for the difference-engine step sequencer.
package babbage_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EMIT,
      ADD0,
      ADD1,
      DONE
   } state_t;

   localparam logic [2:0] DSEL_IDLE = 3'b000;
   localparam logic [2:0] DSEL_LOAD = 3'b001;
   localparam logic [2:0] DSEL_EMIT = 3'b111;
   localparam logic [2:0] DSEL_ADD0 = 3'b101;
   localparam logic [2:0] DSEL_ADD1 = 3'b011;

   function automatic logic is_busy(input state_t s);
      return (s == LOAD) || (s == EMIT) || (s == ADD0) || (s == ADD1);
   endfunction

endpackage

// File: rtl/babbage_step_seq.sv
// Phase sequencer for the difference-engine datapath: LOAD, then EMIT/ADD0/ADD1 per term.
// Optional abort input and aborted strobe are enabled by defining SEQ_ABORT_EN.
module babbage_step_seq
   import babbage_pkg::*;
#(
   parameter int N_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N_W-1:0] n_terms,
   input  logic           hold,
`ifdef SEQ_ABORT_EN
   input  logic           abort,
   output logic           aborted,
`endif
   output logic [2:0]     dsel,
   output logic           we_d0,
   output logic           we_d1,
   output logic           we_d2,
   output logic           out_valid,
   output logic [N_W-1:0] term_idx,
   output logic           busy,
   output logic           done
);

   localparam logic [N_W-1:0] ONE = N_W'(1);

   state_t         state, state_n;
   logic [N_W-1:0] count, count_n;
   logic [N_W-1:0] nlat, nlat_n;
   logic           frozen;

   logic [2:0]     dsel_n;
   logic           we_d0_n, we_d1_n, we_d2_n, out_valid_n, busy_n, done_n;
   logic [N_W-1:0] term_idx_n;
`ifdef SEQ_ABORT_EN
   logic           aborted_n;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         nlat  <= '0;
      end else begin
         state <= state_n;
         count <= count_n;
         nlat  <= nlat_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      nlat_n  = nlat;
      frozen  = 1'b0;
`ifdef SEQ_ABORT_EN
      aborted_n = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (start) begin
               if (n_terms != '0) begin
                  nlat_n  = n_terms;
                  count_n = '0;
                  state_n = LOAD;
               end else begin
                  state_n = DONE;
               end
            end
         end
         LOAD: state_n = EMIT;
         EMIT: begin
            if (hold)                    frozen  = 1'b1;
            else if (count == nlat - ONE) state_n = DONE;
            else                          state_n = ADD0;
         end
         ADD0: begin
            if (hold) frozen  = 1'b1;
            else      state_n = ADD1;
         end
         ADD1: begin
            if (hold) begin
               frozen = 1'b1;
            end else begin
               count_n = count + ONE;
               state_n = EMIT;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

`ifdef SEQ_ABORT_EN
      // abort wins over hold: drop straight to IDLE without a done pulse
      if (abort && is_busy(state)) begin
         state_n   = IDLE;
         count_n   = count;
         frozen    = 1'b0;
         aborted_n = 1'b1;
      end
`endif

      // Outputs are decoded from the state being entered and registered,
      // so they line up with that state's cycle without any input-to-output path.
      dsel_n      = DSEL_IDLE;
      we_d0_n     = 1'b0;
      we_d1_n     = 1'b0;
      we_d2_n     = 1'b0;
      out_valid_n = 1'b0;
      term_idx_n  = '0;
      busy_n      = is_busy(state_n);
      done_n      = (state_n == DONE);

      case (state_n)
         LOAD: begin
            dsel_n  = DSEL_LOAD;
            we_d0_n = 1'b1;
            we_d1_n = 1'b1;
            we_d2_n = 1'b1;
         end
         EMIT: begin
            dsel_n      = DSEL_EMIT;
            out_valid_n = !frozen;
            term_idx_n  = count_n;
         end
         ADD0: begin
            dsel_n  = DSEL_ADD0;
            we_d0_n = !frozen;
         end
         ADD1: begin
            dsel_n  = DSEL_ADD1;
            we_d1_n = !frozen;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dsel      <= DSEL_IDLE;
         we_d0     <= 1'b0;
         we_d1     <= 1'b0;
         we_d2     <= 1'b0;
         out_valid <= 1'b0;
         term_idx  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef SEQ_ABORT_EN
         aborted   <= 1'b0;
`endif
      end else begin
         dsel      <= dsel_n;
         we_d0     <= we_d0_n;
         we_d1     <= we_d1_n;
         we_d2     <= we_d2_n;
         out_valid <= out_valid_n;
         term_idx  <= term_idx_n;
         busy      <= busy_n;
         done      <= done_n;
`ifdef SEQ_ABORT_EN
         aborted   <= aborted_n;
`endif
      end
   end

endmodule

// File: tb/tb_babbage_step_seq.sv
// Scoreboard bench for babbage_step_seq: per-cycle expected outputs from a phase-list model.
module tb_babbage_step_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       hold = 1'b0;
   logic [7:0] n_terms = '0;
   logic [2:0] dsel;
   logic       we_d0, we_d1, we_d2, out_valid, busy, done;
   logic [7:0] term_idx;
   logic       aborted;
`ifdef SEQ_ABORT_EN
   logic       abort = 1'b0;
`else
   assign aborted = 1'b0;
`endif

   babbage_step_seq #(.N_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .n_terms(n_terms), .hold(hold),
`ifdef SEQ_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .dsel(dsel), .we_d0(we_d0), .we_d1(we_d1), .we_d2(we_d2),
      .out_valid(out_valid), .term_idx(term_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] dsel;
      logic       we0, we1, we2, ov;
      logic [7:0] idx;
      logic       busy, done, ab;
   } vec_t;

   vec_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;
   bit   hold_s[1024];

   // phase ids: 0 LOAD, 1 EMIT, 2 ADD0, 3 ADD1, 4 DONE
   function automatic vec_t mkvec(input int ph, input int k, input bit frozen);
      vec_t v = '0;
      case (ph)
         0: begin v.dsel = 3'b001; v.we0 = 1; v.we1 = 1; v.we2 = 1; v.busy = 1; end
         1: begin v.dsel = 3'b111; v.ov = !frozen; v.idx = 8'(k); v.busy = 1; end
         2: begin v.dsel = 3'b101; v.we0 = !frozen; v.busy = 1; end
         3: begin v.dsel = 3'b011; v.we1 = !frozen; v.busy = 1; end
         default: v.done = 1;
      endcase
      return v;
   endfunction

   // Expected cycle-by-cycle outputs; cycle 1 follows the edge that accepts start.
   // hold_s[c] / abort_at==c describe the inputs seen at the edge that opens cycle c.
   task automatic build(input int n, input int abort_at, output int len);
      int   ph[$];
      int   kk[$];
      int   c = 0;
      int   p, k;
      vec_t av = '0;
      av.ab = 1'b1;
      if (n == 0) begin
         q.push_back(mkvec(4, 0, 0));
         len = 1;
         return;
      end
      ph.push_back(0); kk.push_back(0);
      for (int t = 0; t < n; t++) begin
         ph.push_back(1); kk.push_back(t);
         if (t < n - 1) begin
            ph.push_back(2); kk.push_back(t);
            ph.push_back(3); kk.push_back(t);
         end
      end
      ph.push_back(4); kk.push_back(0);
      while (ph.size() > 0) begin
         p = ph.pop_front();
         k = kk.pop_front();
         c++;
         if (abort_at == c) begin
            q.push_back(av);
            len = c;
            return;
         end
         q.push_back(mkvec(p, k, 0));
         while (p >= 1 && p <= 3 && hold_s[c+1] && abort_at != c + 1) begin
            c++;
            q.push_back(mkvec(p, k, 1));
         end
      end
      len = c;
   endtask

   task automatic set_abort(input bit v);
`ifdef SEQ_ABORT_EN
      abort = v;
`else
      if (v) $display("note: abort requested without SEQ_ABORT_EN");
`endif
   endtask

   task automatic fill_hold(input int pct);
      for (int i = 0; i < 1024; i++) hold_s[i] = ($urandom_range(0, 99) < pct);
   endtask

   task automatic idle(input int m);
      for (int i = 0; i < m; i++) begin
         @(negedge clk);
         start = 1'b0;
         hold  = 1'($urandom);
`ifdef SEQ_ABORT_EN
         abort = 1'($urandom);
`endif
      end
      @(negedge clk);
      set_abort(1'b0);
   endtask

   task automatic run(input int n, input int abort_at, input int rst_at, input bit noise);
      int len;
      @(negedge clk);
      build(n, abort_at, len);
      start   = 1'b1;
      n_terms = 8'(n);
      hold    = hold_s[1];
      set_abort(1'b0);
      for (int c = 1; c <= len; c++) begin
         @(negedge clk);
         if (rst_at == c) begin
            rst = 1'b1;
            q.delete();
            #1;
            tests++;
            if ({dsel, we_d0, we_d1, we_d2, out_valid, term_idx, busy, done, aborted} != '0) begin
               fails++;
               $display("FAIL async_reset got=%h required=0", {dsel, we_d0, we_d1, we_d2, out_valid, term_idx, busy, done, aborted});
            end
            @(negedge clk);
            rst   = 1'b0;
            start = 1'b0;
            hold  = 1'b0;
            set_abort(1'b0);
            return;
         end
         start = noise && (c < len) && ($urandom_range(0, 3) == 0);
         if (noise) n_terms = 8'($urandom);
         hold = hold_s[c+1];
         set_abort(abort_at == c + 1);
      end
   endtask

   initial begin
      vec_t act, exp;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && !rst) begin
            act = {dsel, we_d0, we_d1, we_d2, out_valid, term_idx, busy, done, aborted};
            exp = (q.size() > 0) ? q.pop_front() : '0;
            tests++;
            if (act !== exp) begin
               fails++;
               $display("FAIL outputs t=%0t got dsel=%b we=%b%b%b ov=%b idx=%0d busy=%b done=%b ab=%b required dsel=%b we=%b%b%b ov=%b idx=%0d busy=%b done=%b ab=%b",
                        $time, act.dsel, act.we0, act.we1, act.we2, act.ov, act.idx, act.busy, act.done, act.ab,
                        exp.dsel, exp.we0, exp.we1, exp.we2, exp.ov, exp.idx, exp.busy, exp.done, exp.ab);
            end
         end
      end
   end

   initial begin
      int n, ab;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      fill_hold(0);
      run(4, 0, 0, 0);
      idle(2);
      run(0, 0, 0, 0);
      idle(2);

      hold_s[4] = 1; hold_s[5] = 1; hold_s[6] = 1;
      run(3, 0, 0, 0);
      idle(2);

      fill_hold(0);
      run(5, 0, 6, 0);
      run(5, 0, 0, 0);
      idle(1);
      run(4, 0, 0, 1);
      idle(2);
`ifdef SEQ_ABORT_EN
      run(4, 6, 0, 0);
      idle(2);
`endif
      run(255, 0, 0, 0);
      idle(2);
      run(1, 0, 0, 1);

      for (int r = 0; r < 40; r++) begin
         fill_hold(20);
         n  = $urandom_range(0, 12);
         ab = 0;
`ifdef SEQ_ABORT_EN
         if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(2, 3 * n);
`endif
         run(n, ab, 0, 1);
         idle($urandom_range(0, 3));
      end

      idle(3);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got=%0d pending required=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
